an_encoder_n29_6x6_stream: RTL

//  Transmit-side counterpart of the 6x6 AN(A=29) array decoder.
//  - Accepts a stream of messages and encodes each as codeword = A*message.
//  - Tags every codeword with its (row,col) slot in a 6x6 frame, filled row-major.
//  - Emits codewords on a registered valid/ready stream; frame start and end are marked.

---
 rtl/an_encoder_n29_6x6_stream.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/an_encoder_n29_6x6_stream.sv
// AN (A=29) stream encoder: codeword = A*msg, tagged with its row-major slot in a 6x6 frame.
// Optional macro ERR_INJECT_EN adds a single-bit fault injector ahead of the output register.
module an_encoder_n29_6x6_stream #(
    parameter int A     = 29,
    parameter int MSG_W = 10,
    parameter int CW_W  = 14,
    parameter int ROWS  = 6,
    parameter int COLS  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MSG_W-1:0] in_msg,
    input  logic             frame_restart,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW_W-1:0]  out_cw,
    output logic [2:0]       out_row,
    output logic [2:0]       out_col,
    output logic             out_sof,
    output logic             out_eof,
    output logic             out_ovf
`ifdef ERR_INJECT_EN
    ,
    input  logic             inj_en,
    input  logic [5:0]       inj_pos,
    input  logic [3:0]       inj_bit
`endif
);

    localparam int P_W = MSG_W + 5;
    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
    localparam logic [2:0] LAST_COL = 3'(COLS - 1);

    logic              r_init;
    logic              r_out_valid;
    logic [CW_W-1:0]   r_out_cw;
    logic [2:0]        r_out_row;
    logic [2:0]        r_out_col;
    logic              r_out_sof;
    logic              r_out_eof;
    logic              r_out_ovf;
    logic [2:0]        r_row;
    logic [2:0]        r_col;

    logic              w_accept;
    logic [P_W-1:0]    w_pp [0:5];
    logic [P_W-1:0]    w_prod;
    logic [CW_W-1:0]   w_cw;
    logic              w_ovf;
    logic [2:0]        w_slot_row;
    logic [2:0]        w_slot_col;
    logic [2:0]        w_next_row;
    logic [2:0]        w_next_col;

    // Constant multiply as a shift-add chain over the set bits of A (A < 32).
    assign w_pp[0] = '0;
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_shift_add
            if (A[gi]) begin : g_term
                assign w_pp[gi+1] = w_pp[gi] + (P_W'(in_msg) << gi);
            end else begin : g_skip
                assign w_pp[gi+1] = w_pp[gi];
            end
        end
    endgenerate

    assign w_prod = w_pp[5];
    assign w_ovf  = |w_prod[P_W-1:CW_W];

    // A restart pulls the accepted message into slot (0,0).
    assign w_slot_row = frame_restart ? 3'd0 : r_row;
    assign w_slot_col = frame_restart ? 3'd0 : r_col;

    always_comb begin
        w_next_row = w_slot_row;
        w_next_col = w_slot_col + 3'd1;
        if (w_slot_col == LAST_COL) begin
            w_next_col = 3'd0;
            w_next_row = (w_slot_row == LAST_ROW) ? 3'd0 : w_slot_row + 3'd1;
        end
    end

`ifdef ERR_INJECT_EN
    logic [5:0]      w_slot_idx;
    logic            w_flip;
    assign w_slot_idx = 6'(w_slot_row) * 6'(COLS) + 6'(w_slot_col);
    assign w_flip     = inj_en && (w_slot_idx == inj_pos) && (32'(inj_bit) < CW_W);
    assign w_cw       = w_prod[CW_W-1:0] ^ (w_flip ? (CW_W'(1) << inj_bit) : '0);
`else
    assign w_cw       = w_prod[CW_W-1:0];
`endif

    // r_init holds in_ready low until the first edge after reset release.
    assign in_ready = r_init & (~r_out_valid | out_ready);
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_cw    <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
        end else begin
            r_init <= 1'b1;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_cw    <= w_cw;
                r_out_ovf   <= w_ovf;
                r_out_row   <= w_slot_row;
                r_out_col   <= w_slot_col;
                r_out_sof   <= (w_slot_row == 3'd0) && (w_slot_col == 3'd0);
                r_out_eof   <= (w_slot_row == LAST_ROW) && (w_slot_col == LAST_COL);
                r_row       <= w_next_row;
                r_col       <= w_next_col;
            end else begin
                if (r_out_valid && out_ready) begin
                    r_out_valid <= 1'b0;
                end
                if (frame_restart) begin
                    r_row <= 3'd0;
                    r_col <= 3'd0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_cw    = r_out_cw;
    assign out_row   = r_out_row;
    assign out_col   = r_out_col;
    assign out_sof   = r_out_sof;
    assign out_eof   = r_out_eof;
    assign out_ovf   = r_out_ovf;

endmodule
